// File: rtl/counter_bus_sequencer.sv
// Bus master that loads, verifies and runs one
// 8-bit up/down counter peripheral on a shared bus.
module counter_bus_sequencer #(
  parameter int STROBE_CYC = 2,
  parameter int TO_W       = 18,
  parameter int TIMEOUT    = 200000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cfg_valid,
  output logic       cfg_ready,
  input  logic [7:0] cfg_plr,
  input  logic [7:0] cfg_ulr,
  input  logic [7:0] cfg_llr,
  input  logic [7:0] cfg_ccr,
  output logic       bus_ncs,
  output logic       bus_nwr,
  output logic       bus_nrd,
  output logic [1:0] bus_addr,
  output logic [7:0] bus_dout,
  output logic       bus_oe,
  input  logic [7:0] bus_din,
  input  logic       cnt_err,
  input  logic       cnt_ec,
  output logic       cnt_start,
  output logic       busy,
  output logic       done,
  output logic       fail,
  output logic [1:0] fail_code
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_CHKERR,
    S_START,
    S_WAITEC,
    S_FIN
  } state_e;

  typedef enum logic [1:0] {
    PH_SET,
    PH_STB,
    PH_HLD
  } phase_e;

  localparam int CW = $clog2(STROBE_CYC + 3);

  localparam logic [CW-1:0] WR_LAST =
    CW'(STROBE_CYC - 1);
  localparam logic [CW-1:0] RD_LAST =
    CW'(STROBE_CYC);
  localparam logic [CW-1:0] CHK_LAST = CW'(2);
  // FIN lands exactly TIMEOUT cycles after START
  localparam logic [TO_W-1:0] TO_LAST =
    TO_W'(TIMEOUT - 2);

  state_e            state_q, state_d;
  phase_e            ph_q, ph_d;
  logic [1:0]        idx_q, idx_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [TO_W-1:0]   to_q, to_d;
  logic [1:0]        code_q, code_d;
  logic [3:0][7:0]   val_q, val_d;
  logic              ec_seen_q;

  // Sequencer state registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      ph_q    <= PH_SET;
      idx_q   <= 2'd0;
      cnt_q   <= '0;
      to_q    <= '0;
      code_q  <= 2'd0;
      val_q   <= '0;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
      code_q  <= code_d;
      val_q   <= val_d;
    end
  end

  // Catch sub-cycle ec pulses; sticky while waiting
  always_ff @(negedge clk) begin
    if (!reset) begin
      ec_seen_q <= 1'b0;
    end else if (state_q != S_WAITEC) begin
      ec_seen_q <= 1'b0;
    end else if (cnt_ec) begin
      ec_seen_q <= 1'b1;
    end
  end

  // Next-state: bus access sequencing and verdict
  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    to_d    = '0;
    code_d  = code_q;
    val_d   = val_q;
    unique case (state_q)
      S_IDLE: begin
        if (cfg_valid) begin
          val_d  = {cfg_ccr, cfg_llr,
                    cfg_ulr, cfg_plr};
          code_d = 2'd0;
          idx_d  = 2'd0;
          ph_d   = PH_SET;
          cnt_d  = '0;
          if (cfg_plr < cfg_llr ||
              cfg_plr > cfg_ulr) begin
            code_d  = 2'd1;
            state_d = S_FIN;
          end else begin
            state_d = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        unique case (ph_q)
          PH_SET: begin
            ph_d  = PH_STB;
            cnt_d = '0;
          end
          PH_STB: begin
            if (cnt_q == WR_LAST) ph_d = PH_HLD;
            else cnt_d = cnt_q + 1'b1;
          end
          PH_HLD: begin
            ph_d  = PH_SET;
            idx_d = idx_q + 2'd1;
            if (idx_q == 2'd3) state_d = S_READ;
          end
          default: ph_d = PH_SET;
        endcase
      end
      S_READ: begin
        unique case (ph_q)
          PH_SET: begin
            ph_d  = PH_STB;
            cnt_d = '0;
          end
          PH_STB: begin
            if (cnt_q != RD_LAST) begin
              cnt_d = cnt_q + 1'b1;
            end else if (bus_din !=
                         val_q[idx_q]) begin
              code_d  = 2'd2;
              state_d = S_FIN;
            end else begin
              ph_d  = PH_SET;
              idx_d = idx_q + 2'd1;
              if (idx_q == 2'd3) begin
                state_d = S_CHKERR;
                cnt_d   = '0;
              end
            end
          end
          default: ph_d = PH_SET;
        endcase
      end
      S_CHKERR: begin
        if (cnt_q != CHK_LAST) begin
          cnt_d = cnt_q + 1'b1;
        end else if (cnt_err) begin
          code_d  = 2'd1;
          state_d = S_FIN;
        end else begin
          state_d = S_START;
        end
      end
      S_START: state_d = S_WAITEC;
      S_WAITEC: begin
        if (ec_seen_q) begin
          code_d  = 2'd0;
          state_d = S_FIN;
        end else if (to_q == TO_LAST) begin
          code_d  = 2'd3;
          state_d = S_FIN;
        end else begin
          to_d = to_q + 1'b1;
        end
      end
      S_FIN: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Chip select spans write through end-of-cycle wait
  assign bus_ncs = !(state_q inside
    {S_WRITE, S_READ, S_CHKERR,
     S_START, S_WAITEC});

  assign bus_nwr = !(state_q == S_WRITE &&
                     ph_q == PH_STB);
  assign bus_nrd = !(state_q == S_READ &&
                     ph_q == PH_STB);
  assign bus_oe  = (state_q == S_WRITE);

  assign bus_addr =
    (state_q == S_WRITE || state_q == S_READ) ?
    idx_q : 2'd0;
  assign bus_dout =
    (state_q == S_WRITE) ? val_q[idx_q] : 8'h00;

  assign cnt_start = (state_q == S_START);
  assign cfg_ready = reset && (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_FIN);
  assign fail      = done && (code_q != 2'd0);
  assign fail_code = code_q;

endmodule

// File: tb/tb_counter_bus_sequencer.sv
// Scoreboard bench for counter_bus_sequencer with a
// behavioural counter peripheral and reference model.
module tb_counter_bus_sequencer;

  localparam int SC   = 2;
  localparam int TOUT = 50;

  typedef struct {
    logic [1:0] code;
    int         wr;
    int         rd;
    int         st;
    bit         to;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [7:0] cfg_plr, cfg_ulr, cfg_llr, cfg_ccr;
  logic       bus_ncs, bus_nwr, bus_nrd, bus_oe;
  logic [1:0] bus_addr;
  logic [7:0] bus_dout, bus_din;
  logic       cnt_err, cnt_ec, cnt_start;
  logic       busy, done, fail;
  logic [1:0] fail_code;

  int errors = 0;
  int checks = 0;

  exp_t q[$];

  // peripheral side
  logic [7:0] regs [4] = '{default: 8'h00};
  bit         lock;
  bit         ec_en;
  int         late_cnt;
  int         served;

  // reference side
  logic [7:0] ref_regs [4] = '{default: 8'h00};
  bit         ref_lock = 1'b0;

  always #5 clk = ~clk;

  counter_bus_sequencer #(
    .STROBE_CYC(SC),
    .TO_W(18),
    .TIMEOUT(TOUT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_plr(cfg_plr),
    .cfg_ulr(cfg_ulr),
    .cfg_llr(cfg_llr),
    .cfg_ccr(cfg_ccr),
    .bus_ncs(bus_ncs),
    .bus_nwr(bus_nwr),
    .bus_nrd(bus_nrd),
    .bus_addr(bus_addr),
    .bus_dout(bus_dout),
    .bus_oe(bus_oe),
    .bus_din(bus_din),
    .cnt_err(cnt_err),
    .cnt_ec(cnt_ec),
    .cnt_start(cnt_start),
    .busy(busy),
    .done(done),
    .fail(fail),
    .fail_code(fail_code)
  );

  task automatic chk(input string name,
                     input int act,
                     input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d",
               name, act, exp);
    end
  endtask

  // counter register file; writes refused while locked
  assign bus_din = regs[bus_addr];

  always @(negedge clk) begin
    if (!bus_ncs && !bus_nwr && !lock)
      regs[bus_addr] <= bus_dout;
  end

  // counter run: ec after CCR full sweeps, short pulse
  initial begin
    int d;
    cnt_ec = 1'b0;
    lock   = 1'b0;
    served = 0;
    forever begin
      @(negedge clk);
      if (cnt_start) begin
        lock = 1'b1;
        if (ec_en) begin
          d = int'(regs[3]) * 2 *
              (int'(regs[1]) - int'(regs[2]));
          @(posedge clk);
          repeat (d) @(posedge clk);
          #1 cnt_ec = 1'b1;
          #5 cnt_ec = 1'b0;
          lock = 1'b0;
        end
      end else if (late_cnt != served) begin
        served = late_cnt;
        #1 cnt_ec = 1'b1;
        #5 cnt_ec = 1'b0;
        lock = 1'b0;
      end
    end
  end

  // monitor: bus rules every cycle, verdict on done
  int cyc = 0;
  int wr_n = 0;
  int rd_n = 0;
  int st_n = 0;
  int st_cyc = 0;

  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (!reset) begin
      wr_n = 0;
      rd_n = 0;
      st_n = 0;
    end else begin
      chk("strobe_overlap",
          int'(!bus_nwr && !bus_nrd), 0);
      chk("oe_rule",
          int'(bus_oe && (bus_ncs || !bus_nrd)), 0);
      if (!bus_nwr) wr_n++;
      if (!bus_nrd) rd_n++;
      if (cnt_start) begin
        st_n++;
        st_cyc = cyc;
      end
      if (done) begin
        chk("done_pending", int'(q.size() != 0), 1);
        if (q.size() != 0) begin
          e = q.pop_front();
          chk("fail_code", int'(fail_code),
              int'(e.code));
          chk("fail", int'(fail),
              int'(e.code != 2'd0));
          chk("write_cycles", wr_n, e.wr);
          chk("read_cycles", rd_n, e.rd);
          chk("start_pulses", st_n, e.st);
          chk("ncs_at_done", int'(bus_ncs), 1);
          if (e.to)
            chk("timeout_dist", cyc - st_cyc, TOUT);
        end
        wr_n = 0;
        rd_n = 0;
        st_n = 0;
      end
    end
  end

  task automatic run(input logic [7:0] p,
                     input logic [7:0] u,
                     input logic [7:0] l,
                     input logic [7:0] c,
                     input bit err,
                     input bit ec,
                     input bit abort);
    exp_t       e;
    logic [7:0] nv [4];
    int         mm;
    int         k;
    bit         seen;
    nv     = '{p, u, l, c};
    e.to   = 1'b0;
    e.st   = 0;
    e.wr   = 0;
    e.rd   = 0;
    e.code = 2'd0;
    if (p < l || p > u) begin
      e.code = 2'd1;
    end else begin
      e.wr = 4 * SC;
      if (!ref_lock)
        for (int i = 0; i < 4; i++)
          ref_regs[i] = nv[i];
      mm = -1;
      for (int i = 0; i < 4; i++)
        if (mm < 0 && ref_regs[i] != nv[i]) mm = i;
      if (mm >= 0) begin
        e.code = 2'd2;
        e.rd   = (SC + 1) * (mm + 1);
      end else begin
        e.rd = 4 * (SC + 1);
        if (err) begin
          e.code = 2'd1;
        end else begin
          e.st     = 1;
          e.code   = ec ? 2'd0 : 2'd3;
          e.to     = !ec;
          ref_lock = !ec;
        end
      end
    end
    k = 0;
    @(negedge clk);
    while (!cfg_ready && k < 400) begin
      @(negedge clk);
      k++;
    end
    chk("ready_wait", int'(cfg_ready), 1);
    cfg_plr   = p;
    cfg_ulr   = u;
    cfg_llr   = l;
    cfg_ccr   = c;
    cnt_err   = err;
    ec_en     = ec;
    cfg_valid = 1'b1;
    if (!abort) q.push_back(e);
    @(posedge clk);
    #1 cfg_valid = 1'b0;
    if (abort) return;
    if (e.code == 2'd1 && e.wr == 0) begin
      seen = 1'b0;
      for (int i = 0; i < 2; i++) begin
        @(negedge clk);
        if (cfg_ready) seen = 1'b1;
      end
      chk("range_ready_back", int'(seen), 1);
    end
    k = 0;
    @(negedge clk);
    while (busy && k < 400) begin
      @(negedge clk);
      k++;
    end
    chk("run_finished", int'(busy), 0);
  endtask

  task automatic late_ec();
    late_cnt++;
    ref_lock = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int l, u, p, c, sel, k;
    bit er, ec;
    reset     = 1'b0;
    cfg_valid = 1'b0;
    cfg_plr   = 8'h00;
    cfg_ulr   = 8'h00;
    cfg_llr   = 8'h00;
    cfg_ccr   = 8'h00;
    cnt_err   = 1'b0;
    ec_en     = 1'b1;
    late_cnt  = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", int'(cfg_ready), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ncs", int'(bus_ncs), 1);
    chk("rst_nwr", int'(bus_nwr), 1);
    chk("rst_nrd", int'(bus_nrd), 1);
    chk("rst_oe", int'(bus_oe), 0);
    chk("rst_addr", int'(bus_addr), 0);
    chk("rst_dout", int'(bus_dout), 0);
    chk("rst_start", int'(cnt_start), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_fail", int'(fail), 0);
    chk("rst_code", int'(fail_code), 0);
    reset = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", int'(cfg_ready), 1);

    run(8'd5, 8'd8, 8'd3, 8'd1, 0, 1, 0);
    run(8'd2, 8'd9, 8'd4, 8'd1, 0, 1, 0);
    run(8'd4, 8'd6, 8'd2, 8'd1, 0, 0, 0);
    run(8'd5, 8'd6, 8'd2, 8'd1, 0, 1, 0);
    late_ec();
    run(8'd7, 8'd7, 8'd7, 8'd0, 0, 1, 0);
    run(8'd7, 8'd9, 8'd3, 8'd2, 1, 1, 0);

    for (int n = 0; n < 25; n++) begin
      l   = int'($urandom_range(0, 240));
      u   = l + int'($urandom_range(0, 6));
      sel = int'($urandom_range(0, 9));
      if (sel == 0 && l > 0) p = l - 1;
      else if (sel <= 1) p = u + 1;
      else p = l + int'($urandom_range(0, u - l));
      c  = int'($urandom_range(0, 3));
      er = ($urandom_range(0, 7) == 0);
      ec = ($urandom_range(0, 7) != 0);
      run(8'(p), 8'(u), 8'(l), 8'(c), er, ec, 0);
      if (ref_lock && $urandom_range(0, 1) == 1)
        late_ec();
    end

    if (ref_lock) late_ec();
    run(8'd9, 8'd12, 8'd8, 8'd2, 0, 1, 1);
    k = 0;
    @(negedge clk);
    while (!(bus_addr == 2'd2 && !bus_nwr) &&
           k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("reach_wr2", int'(!bus_nwr), 1);
    #1 reset = 1'b0;
    chk("ready_in_rst", int'(cfg_ready), 0);
    @(posedge clk);
    #1;
    chk("abort_ncs", int'(bus_ncs), 1);
    chk("abort_nwr", int'(bus_nwr), 1);
    chk("abort_nrd", int'(bus_nrd), 1);
    chk("abort_oe", int'(bus_oe), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_start", int'(cnt_start), 0);
    ref_regs[0] = 8'd9;
    ref_regs[1] = 8'd12;
    ref_regs[2] = 8'd8;
    @(negedge clk);
    #1 reset = 1'b1;
    run(8'd9, 8'd12, 8'd8, 8'd2, 0, 1, 0);

    repeat (5) @(negedge clk);
    chk("queue_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule

// File: doc/counter_bus_sequencer.md
Name: counter_bus_sequencer

Overview:
- Bus master that configures and runs one 8-bit up/down counter peripheral on a shared register bus.
- Accepts one run request holding PLR, ULR, LLR and CCR values, then:
  - writes all four registers,
  - reads them back to verify,
  - checks the counter's err flag,
  - issues a single start pulse,
  - waits for the counter's end-of-cycle flag and reports pass or fail.
- Sits between the system controller and the counter, so software never toggles counter strobes by hand.

Parameters:
- STROBE_CYC, 2, number of cycles nwr or nrd is held low per bus access (minimum 1).
- TO_W, 18, width of the end-of-cycle timeout counter.
- TIMEOUT, 200000, cycles to wait for cnt_ec after start before failing.

Ports:
- clk  in  1  clock; all logic is rising-edge except the ec_seen capture flop.
- reset  in  1  synchronous, active-low.
- cfg_valid  in  1  run request.
- cfg_ready  out  1  high in IDLE only.
- cfg_plr, cfg_ulr, cfg_llr, cfg_ccr  in  8 each  values to load; captured when cfg_valid and cfg_ready are both high.
- bus_ncs  out  1  chip select, active-low.
- bus_nwr  out  1  write strobe, active-low.
- bus_nrd  out  1  read strobe, active-low.
- bus_addr  out  2  register select: 0=PLR, 1=ULR, 2=LLR, 3=CCR.
- bus_dout  out  8  write data.
- bus_oe  out  1  drive enable for bus_dout onto the shared data bus.
- bus_din  in  8  read data from the bus.
- cnt_err  in  1  counter range-error flag.
- cnt_ec  in  1  counter end-of-cycle flag; may be high for less than one clock period.
- cnt_start  out  1  start pulse to the counter.
- busy  out  1  high outside IDLE.
- done  out  1  one-cycle completion pulse.
- fail  out  1  qualifies done: 1 means the run failed.
- fail_code  out  2  valid with done: 0=ok, 1=range error, 2=readback mismatch, 3=timeout.

Behaviour:
- Reset (reset==0 at a posedge):
  - state=IDLE.
  - bus_ncs=1, bus_nwr=1, bus_nrd=1, bus_addr=0, bus_dout=0, bus_oe=0.
  - cnt_start=0, done=0, fail=0, fail_code=0, busy=0, ec_seen=0.
  - Timeout and strobe counters cleared.
  - cfg_ready=0 while reset is held.
  - Reset mid-run aborts at once with no done pulse; the counter's own state is not touched.
- IDLE: cfg_ready=1. On handshake, capture all four values.
  - If PLR<LLR or PLR>ULR: go to FIN with fail_code=1; no bus activity occurs.
  - Otherwise go to WRITE with idx=0.
- WRITE: one access per idx, 0 to 3.
  - Setup cycle: bus_ncs=0, bus_addr=idx, bus_dout=value, bus_oe=1, bus_nwr=1.
  - Strobe: bus_nwr=0 for STROBE_CYC cycles.
  - Hold cycle: bus_nwr=1, with addr, data and oe unchanged.
  - Then advance idx. After idx 3, go to READ with idx=0.
- READ: bus_oe=0.
  - Setup cycle, then bus_nrd=0 for STROBE_CYC+1 cycles.
  - bus_din is compared on the last low cycle.
  - First mismatch goes to FIN with fail_code=2. This covers the counter's write-lock: registers written before the previous run ended are rejected.
  - After idx 3 matches, go to CHKERR.
- CHKERR: wait 2 cycles, then sample cnt_err.
  - cnt_err=1: go to FIN with fail_code=1.
  - Otherwise go to START.
- START: cnt_start=1 for exactly one cycle, then go to WAITEC. Timeout counter is cleared and ec_seen=0.
- WAITEC:
  - ec_seen is sampled from cnt_ec on the falling edge of clk and is sticky until it leaves WAITEC.
  - ec_seen=1: go to FIN with fail_code=0.
  - Timeout counter reaches TIMEOUT: go to FIN with fail_code=3.
  - CCR=0 is legal: the counter raises ec right after start, and the run completes in WAITEC.
- FIN: for one cycle:
  - done=1, fail=(fail_code!=0).
  - bus_ncs=1, all strobes high, bus_oe=0.
  - Then go to IDLE.
- Bus rules:
  - bus_ncs stays low continuously from the first WRITE setup through WAITEC, because the counter only counts while selected.
  - nwr and nrd are never low together.
  - bus_oe=1 only in WRITE.
- cfg_valid is ignored while busy.

Test Plan:
- PLR=5, ULR=8, LLR=3, CCR=1 -> 4 writes then 4 matching reads; 1 start pulse; counter runs 5..8..3..5; done=1, fail=0, fail_code=0.
- PLR=2, ULR=9, LLR=4 -> no bus strobes, cfg_ready back to 1 within 2 cycles, done with fail_code=1.
- Second request issued without an intervening ec, bus model keeps old PLR -> READ idx0 mismatch, fail_code=2, bus_ncs=1 after done.
- CCR=0, PLR=ULR=LLR=7 -> ec pulse shorter than one clock caught by ec_seen; done with fail_code=0.
- TIMEOUT=50, counter model never asserts ec -> done with fail_code=3 exactly 50 cycles after start.
- reset=0 held one cycle during the WRITE strobe of idx 2 -> next posedge shows all bus outputs at idle, busy=0, no done pulse.
